// File: rtl/button_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// button_pulse_gen_pkg
//   Shared definitions for the pushbutton pulse generator:
//   - chan_state_e : per-channel auto-repeat FSM state encoding (2 bits)
//   - cnt_width()  : bit width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package button_pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } chan_state_e;

   // Width of a counter that must represent every value 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage : button_pulse_gen_pkg

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One pushbutton: synchroniser, debouncer and press/auto-repeat FSM.
//   Produces a combinational pulse candidate; the top level arbitrates it
//   against the other channel and registers the final output.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   btn_raw_i  in   raw button level (asynchronous, may bounce)
//   held_o     out  debounced button level (registered)
//   pulse_o    out  pulse candidate, valid for the coming clock edge
// -----------------------------------------------------------------------------
module button_channel
   import button_pulse_gen_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 50000,
   parameter int unsigned REPEAT_RATE     = 10000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw_i,
   output logic held_o,
   output logic pulse_o
);

   localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

   localparam logic [DB_W-1:0]  DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_DELAY = TMR_W'(REPEAT_DELAY);
   localparam logic [TMR_W-1:0] TMR_RATE  = TMR_W'(REPEAT_RATE);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_x;
   logic                   held_q, held_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   held_rise, held_fall;
   chan_state_e            state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   pulse_cand;

   assign sync_x = sync_q[SYNC_STAGES-1];

   // Debounce: count consecutive cycles where the synchronised level disagrees
   // with the accepted level. The toggle happens on the edge after the count
   // reaches DEBOUNCE_CYCLES, provided the disagreement still holds.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      held_d   = held_q;
      db_cnt_d = '0;
      if (sync_x != held_q) begin
         if (db_cnt_q == DB_LIMIT) begin
            held_d   = ~held_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Edges are taken from the next-state level so the press pulse lands on
   // the same edge that held goes high.
   assign held_rise = held_d & ~held_q;
   assign held_fall = ~held_d & held_q;

   // Press / auto-repeat FSM. A timer value of 1 means the pulse fires on the
   // coming edge, where the timer would reach 0.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      pulse_cand = 1'b0;
      if (held_fall) begin
         state_d = ST_IDLE;
         tmr_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (held_rise) begin
                  pulse_cand = 1'b1;
                  if (REPEAT_EN) begin
                     state_d = ST_DELAY;
                     tmr_d   = TMR_DELAY;
                  end
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (tmr_q <= TMR_ONE) begin
                  pulse_cand = 1'b1;
                  state_d    = ST_REPEAT;
                  tmr_d      = TMR_RATE;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         held_q   <= 1'b0;
         db_cnt_q <= '0;
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values, keeping the synchroniser a true chain.
         sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
         held_q   <= held_d;
         db_cnt_q <= db_cnt_d;
         state_q  <= state_d;
         tmr_q    <= tmr_d;
      end
   end

   assign held_o  = held_q;
   assign pulse_o = pulse_cand;

endmodule : button_channel

// File: rtl/button_pulse_gen.sv
// -----------------------------------------------------------------------------
// button_pulse_gen
//   Turns raw up/down pushbuttons into clean single-cycle increment and
//   decrement pulses for the up/down counter. Each button gets its own
//   sync/debounce/auto-repeat channel; this level only arbitrates and
//   registers the outputs. Simultaneous candidates cancel each other, so
//   acrescer and decrescer are never high together.
//
// Ports
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   btn_up_raw    in   raw up button, active-high, may bounce
//   btn_down_raw  in   raw down button, active-high, may bounce
//   acrescer      out  one-cycle increment pulse (registered)
//   decrescer     out  one-cycle decrement pulse (registered)
//   up_held       out  debounced up level
//   down_held     out  debounced down level
// -----------------------------------------------------------------------------
module button_pulse_gen
   import button_pulse_gen_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 50000,
   parameter int unsigned REPEAT_RATE     = 10000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic acrescer,
   output logic decrescer,
   output logic up_held,
   output logic down_held
);

   logic up_cand, down_cand;
   logic acrescer_q, decrescer_q;

   button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_up (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_up_raw),
      .held_o   (up_held),
      .pulse_o  (up_cand)
   );

   button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_down (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_down_raw),
      .held_o   (down_held),
      .pulse_o  (down_cand)
   );

   // Conflicting requests cancel; the channel timers keep running regardless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acrescer_q  <= 1'b0;
         decrescer_q <= 1'b0;
      end else begin
         acrescer_q  <= up_cand & ~down_cand;
         decrescer_q <= down_cand & ~up_cand;
      end
   end

   assign acrescer  = acrescer_q;
   assign decrescer = decrescer_q;

endmodule : button_pulse_gen

// File: tb/tb_button_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_button_pulse_gen
//   Scoreboard bench: when a press is driven, the expected pulse edges are
//   pushed into a queue; a monitor on the falling clock edge pops the entry
//   due on that edge and compares both outputs every cycle. A second instance
//   with auto-repeat disabled covers the one-pulse-per-press mode.
//   Edge numbering: edge_no counts rising edges; a raw level driven just
//   after the falling edge where edge_no == n is first sampled at edge n+1.
// -----------------------------------------------------------------------------
module tb_button_pulse_gen;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int DLY  = 20;
   localparam int RATE = 8;
   localparam int LAT  = SYNC + DEB;

   logic clk = 1'b0;
   logic rst_n;
   logic up_raw, dn_raw, up2_raw, dn2_raw;
   logic acrescer, decrescer, up_held, down_held;
   logic acr2, dec2, up2_held, down2_held;

   always #5 clk = ~clk;

   button_pulse_gen #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up_raw(up_raw), .btn_down_raw(dn_raw),
      .acrescer(acrescer), .decrescer(decrescer),
      .up_held(up_held), .down_held(down_held)
   );

   button_pulse_gen #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
   ) dut_norep (
      .clk(clk), .rst_n(rst_n), .btn_up_raw(up2_raw), .btn_down_raw(dn2_raw),
      .acrescer(acr2), .decrescer(dec2),
      .up_held(up2_held), .down_held(down2_held)
   );

   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   typedef struct {
      int at;
      bit is_up;
   } pulse_t;

   pulse_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   int n_pulse2 = 0;
   int first2 = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
      end
   endtask

   // Expected pulses for one press: first at t0, then after DLY, then every
   // RATE, for every edge strictly before stop (release or reset edge).
   task automatic push_train(input int t0, input int stop, input bit up_ch);
      int t   = t0;
      int gap = DLY;
      while (t < stop) begin
         sb.push_back('{at: t, is_up: up_ch});
         t   += gap;
         gap  = RATE;
      end
   endtask

   task automatic goto(input int e);
      while (edge_no < e) @(negedge clk);
   endtask

   always @(negedge clk) begin
      logic ea, ed;
      ea = 1'b0;
      ed = 1'b0;
      if (sb.size() > 0 && sb[0].at == edge_no) begin
         if (sb[0].is_up) ea = 1'b1;
         else             ed = 1'b1;
         void'(sb.pop_front());
      end
      check("acrescer", {31'd0, acrescer}, {31'd0, ea});
      check("decrescer", {31'd0, decrescer}, {31'd0, ed});
      check("norep_decrescer", {31'd0, dec2}, 32'd0);
      if (acr2 === 1'b1) begin
         n_pulse2++;
         if (first2 < 0) first2 = edge_no;
      end
   end

   initial begin
      int n, e, r, t0, t1;
      rst_n   = 1'b0;
      up_raw  = 1'b0;
      dn_raw  = 1'b0;
      up2_raw = 1'b0;
      dn2_raw = 1'b0;

      goto(3);
      check("rst_up_held", {31'd0, up_held}, 32'd0);
      check("rst_down_held", {31'd0, down_held}, 32'd0);
      #1 rst_n = 1'b1;
      goto(8);

      // 1: clean up press, 10 cycles
      n = edge_no;
      push_train(n + 1 + LAT, n + 10 + 1 + LAT, 1'b1);
      #1 up_raw = 1'b1;
      goto(n + LAT);
      check("t1_held_before", {31'd0, up_held}, 32'd0);
      goto(n + LAT + 1);
      check("t1_held_at", {31'd0, up_held}, 32'd1);
      goto(n + 10);
      #1 up_raw = 1'b0;
      goto(n + 30);
      check("t1_held_released", {31'd0, up_held}, 32'd0);

      // 2: bounce every 2 cycles for 12 cycles, then stable high for 10
      n = edge_no;
      push_train(n + 13 + LAT, n + 22 + 1 + LAT, 1'b1);
      for (int i = 0; i < 7; i++) begin
         goto(n + 2 * i);
         #1 up_raw = (i % 2 == 0);
      end
      goto(n + 13 + LAT - 1);
      check("t2_held_before", {31'd0, up_held}, 32'd0);
      goto(n + 13 + LAT);
      check("t2_held_at", {31'd0, up_held}, 32'd1);
      goto(n + 22);
      #1 up_raw = 1'b0;
      goto(n + 40);

      // 3: down held 60 cycles -> press pulse plus five repeats
      n = edge_no;
      push_train(n + 1 + LAT, n + 60 + 1 + LAT, 1'b0);
      #1 dn_raw = 1'b1;
      goto(n + 30);
      check("t3_down_held", {31'd0, down_held}, 32'd1);
      goto(n + 60);
      #1 dn_raw = 1'b0;
      goto(n + 95);
      check("t3_down_released", {31'd0, down_held}, 32'd0);

      // 4: both pressed together -> everything suppressed
      n = edge_no;
      #1 begin
         up_raw = 1'b1;
         dn_raw = 1'b1;
      end
      goto(n + 50);
      check("t4_up_held", {31'd0, up_held}, 32'd1);
      check("t4_down_held", {31'd0, down_held}, 32'd1);
      goto(n + 60);
      #1 begin
         up_raw = 1'b0;
         dn_raw = 1'b0;
      end
      goto(n + 80);

      // 5: reset mid-REPEAT with up held, then a fresh press train
      n  = edge_no;
      t0 = n + 1 + LAT;
      e  = t0 + 38;
      push_train(t0, e + 1, 1'b1);
      #1 up_raw = 1'b1;
      goto(e);
      #1 rst_n = 1'b0;
      goto(e + 1);
      check("t5_rst_up_held", {31'd0, up_held}, 32'd0);
      goto(e + 3);
      r  = edge_no;
      t1 = r + 1 + LAT;
      push_train(t1, t1 + 30 + 1 - 1 + LAT + 1 - LAT + LAT - 1, 1'b1);
      #1 rst_n = 1'b1;
      goto(t1 + 29);
      #1 up_raw = 1'b0;
      goto(t1 + 60);

      // 6: no auto-repeat instance, long hold then a second press
      n = edge_no;
      #1 up2_raw = 1'b1;
      goto(n + 100);
      #1 up2_raw = 1'b0;
      goto(n + 120);
      check("t6_first_count", n_pulse2, 32'd1);
      check("t6_first_edge", first2, n + 1 + LAT);
      #1 up2_raw = 1'b1;
      goto(n + 135);
      #1 up2_raw = 1'b0;
      goto(n + 155);
      check("t6_second_count", n_pulse2, 32'd2);

      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_button_pulse_gen
